subservient_sram_arbiter: RTL
=============================

// Module: subservient_sram_arbiter
// PURPOSE
//  Shares the single 1RW port of the sky130 OpenRAM macro (32x256, 1 kB) between subservient's 8-bit SRAM
//  write port, its 8-bit SRAM read port and the 32-bit Wishbone debug/loader port.
//  Core reads cannot stall, so they always win; a colliding core write is parked in a 1-entry buffer and
//  retired on the next free cycle, with read-after-write forwarding.
//  Sits between subservient and the macro instance in the SoC top.
// PARAMETERS
//  AW      10  byte address width of the core/debug ports; macro word address = AW-2 bits (256 words)
// PORTS
//  i_clk          in   1     clock
//  i_rst_n        in   1     asynchronous reset, active low
//  i_sram_waddr   in   AW    core write byte address
//  i_sram_wdata   in   8     core write data
//  i_sram_wen     in   1     core write strobe (single cycle)
//  i_sram_raddr   in   AW    core read byte address
//  i_sram_ren     in   1     core read strobe (single cycle)
//  o_sram_rdata   out  8     core read data, valid the cycle after i_sram_ren
//  i_debug_mode   in   1     1: debug port owns the macro, core strobes ignored
//  i_wb_dbg_adr   in   32    debug byte address (bits [AW-1:2] used)
//  i_wb_dbg_dat   in   32    debug write data
//  i_wb_dbg_sel   in   4     debug byte enables
//  i_wb_dbg_we    in   1     debug write
//  i_wb_dbg_stb   in   1     debug strobe, held until ack
//  o_wb_dbg_rdt   out  32    debug read data, valid with ack
//  o_wb_dbg_ack   out  1     single-cycle ack
//  o_csb0         out  1     macro chip select, active low
//  o_web0         out  1     macro write enable, active low
//  o_wmask0       out  4     macro byte write mask
//  o_addr0        out  AW-2  macro word address
//  o_din0         out  32    macro write data
//  i_dout0        in   32    macro read data, sampled at the edge after the access
//  o_err          out  1     sticky: write-buffer overflow
// BEHAVIOUR
//  Reset (i_rst_n=0): buffer empty, FSM IDLE, ack=0, err=0, rdt=0, csb0=1, web0=1, wmask0=0, addr0=0, din0=0.
//  Macro outputs are combinational from FSM state, buffer and inputs; one macro access per cycle.
//  Priority (core mode): core read > buffered write > new core write. Core read with new write in the same
//   cycle: read issues, write enters buffer. Write with buffer empty and no read: issued directly.
//  Buffer retires in the first cycle with no core read. New write + no read + buffer full: buffered entry
//   issues and the new write takes its place (FIFO order preserved).
//  Overflow: buffer full, read and write in the same cycle -> new write dropped, o_err=1 until reset.
//  Byte write: wmask0 = 1<<addr[1:0], din0 = {4{wdata}}.
//  Core read: lane = raddr[1:0] registered; o_sram_rdata = i_dout0[lane*8+:8]. Latency 1 cycle.
//  Forwarding: if at read issue the buffer holds the same byte address, the buffered byte replaces the macro
//   byte (flag registered with lane). A write entering the buffer in the same cycle is not forwarded
//   (read precedes write).
//  Debug mode: core strobes ignored (no buffer entry, no err). Debug waits until the buffer is empty.
//  FSM IDLE -> (stb & we & buf empty): issue write, wmask0=sel -> ACK.
//  FSM IDLE -> (stb & !we & buf empty): issue read -> RDWAIT; RDWAIT: capture i_dout0 into rdt -> ACK.
//  FSM ACK: ack=1 for exactly 1 cycle, no macro access -> IDLE. Write latency 1, read latency 2 (stb to ack).
//  Reset mid-operation: FSM to IDLE, pending buffered write discarded, no ack issued.
// CONFIGURATION
//  SUBSERVIENT_SRAM_ARB_STATS_EN defined: adds port o_defer_cnt (out, 16): saturating count of writes
//   deferred into the buffer; reset 0; holds at 16'hFFFF.
//  Undefined: the port and counter are absent; all other behaviour is identical.
// STRUCTURE
//  subservient_sram_pkg: FSM state encoding (IDLE/RDWAIT/ACK), MACRO_DW=32, lane-select and wmask helpers.
//  Sub-module subservient_sram_wbuf: 1-entry write buffer (valid, addr, data), push/pop, address compare
//   for forwarding. Arbitration and FSM stay in this module.
// TESTING
//  Core wen addr 0x005 data 0xA5, no read -> csb0=0, web0=0, addr0=1, wmask0=4'b0010, din0=0xA5A5A5A5.
//  Same-cycle ren 0x010 + wen 0x011 data 0x3C -> read issues first; write retires next cycle,
//   wmask0=4'b0010, addr0=4.
//  Forwarding: ren 0x012 + wen 0x012 (0x77), then ren 0x012 while the write is still buffered -> rdata 0x77.
//  Overflow: buffered write, then two back-to-back read+write cycles -> o_err=1, second write never
//   reaches the macro.
//  Debug: write adr 0x20 dat 0xDEADBEEF sel 4'hF, then read 0x20 -> ack 1 / 2 cycles after stb,
//   rdt=0xDEADBEEF.
//  Reset asserted while buffer full -> buffer cleared, csb0=1, no late write after release.

Source files
------------

// File: rtl/subservient_sram_pkg.sv
// Shared types and helpers for the subservient SRAM arbiter.
// Debug FSM encoding, macro data width, and byte-lane helpers.
package subservient_sram_pkg;

    localparam int MACRO_DW = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RDWAIT = 2'd1,
        ST_ACK    = 2'd2
    } dbg_state_e;

    function automatic logic [3:0] lane_wmask(input logic [1:0] lane);
        lane_wmask = 4'b0001 << lane;
    endfunction

    function automatic logic [7:0] lane_byte(input logic [MACRO_DW-1:0] word, input logic [1:0] lane);
        lane_byte = word[{lane, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/subservient_sram_wbuf.sv
// One-entry parking buffer for core writes that lose arbitration to a core read.
// A push in the same cycle as a pop replaces the entry.
module subservient_sram_wbuf #(
    parameter int AW = 10
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [AW-1:0] i_push_addr,
    input  logic [7:0]    i_push_data,
    input  logic [AW-1:0] i_cmp_addr,
    output logic          o_valid,
    output logic [AW-1:0] o_addr,
    output logic [7:0]    o_data,
    output logic          o_hit
);

    logic          valid_q;
    logic [AW-1:0] addr_q;
    logic [7:0]    data_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else if (i_push) begin
            valid_q <= 1'b1;
            addr_q  <= i_push_addr;
            data_q  <= i_push_data;
        end else if (i_pop) begin
            valid_q <= 1'b0;
        end
    end

    assign o_valid = valid_q;
    assign o_addr  = addr_q;
    assign o_data  = data_q;
    assign o_hit   = valid_q && (addr_q == i_cmp_addr);

endmodule

// File: rtl/subservient_sram_arbiter.sv
// Shares the single 1RW SRAM macro between the core byte ports and the Wishbone debug port.
// Optional SUBSERVIENT_SRAM_ARB_STATS_EN adds o_defer_cnt, a saturating count of deferred writes.
module subservient_sram_arbiter
    import subservient_sram_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [AW-1:0]       i_sram_waddr,
    input  logic [7:0]          i_sram_wdata,
    input  logic                i_sram_wen,
    input  logic [AW-1:0]       i_sram_raddr,
    input  logic                i_sram_ren,
    output logic [7:0]          o_sram_rdata,
    input  logic                i_debug_mode,
    input  logic [31:0]         i_wb_dbg_adr,
    input  logic [31:0]         i_wb_dbg_dat,
    input  logic [3:0]          i_wb_dbg_sel,
    input  logic                i_wb_dbg_we,
    input  logic                i_wb_dbg_stb,
    output logic [31:0]         o_wb_dbg_rdt,
    output logic                o_wb_dbg_ack,
    output logic                o_csb0,
    output logic                o_web0,
    output logic [3:0]          o_wmask0,
    output logic [AW-3:0]       o_addr0,
    output logic [MACRO_DW-1:0] o_din0,
    input  logic [MACRO_DW-1:0] i_dout0,
    output logic                o_err
`ifdef SUBSERVIENT_SRAM_ARB_STATS_EN
    ,
    output logic [15:0]         o_defer_cnt
`endif
);

    dbg_state_e    state_q;
    logic          ack_q;
    logic [31:0]   rdt_q;
    logic          err_q;
    logic [1:0]    rd_lane_q;
    logic          fwd_q;
    logic [7:0]    fwd_data_q;

    logic          core_rd, core_wr;
    logic          buf_valid, buf_hit;
    logic [AW-1:0] buf_addr;
    logic [7:0]    buf_data;
    logic          buf_push, buf_pop, wr_drop, rd_issue, dbg_go;
    logic          unused_adr;

    assign unused_adr = ^{i_wb_dbg_adr[31:AW], i_wb_dbg_adr[1:0]};

    assign core_rd = !i_debug_mode && i_sram_ren;
    assign core_wr = !i_debug_mode && i_sram_wen;

    subservient_sram_wbuf #(.AW(AW)) u_wbuf (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (buf_push),
        .i_pop       (buf_pop),
        .i_push_addr (i_sram_waddr),
        .i_push_data (i_sram_wdata),
        .i_cmp_addr  (i_sram_raddr),
        .o_valid     (buf_valid),
        .o_addr      (buf_addr),
        .o_data      (buf_data),
        .o_hit       (buf_hit)
    );

    // Priority: core read, then buffered write, then new core write, then debug.
    always_comb begin
        o_csb0   = 1'b1;
        o_web0   = 1'b1;
        o_wmask0 = 4'b0000;
        o_addr0  = '0;
        o_din0   = '0;
        buf_push = 1'b0;
        buf_pop  = 1'b0;
        wr_drop  = 1'b0;
        rd_issue = 1'b0;
        dbg_go   = 1'b0;
        if (core_rd) begin
            o_csb0   = 1'b0;
            o_addr0  = i_sram_raddr[AW-1:2];
            rd_issue = 1'b1;
            if (core_wr) begin
                buf_push = !buf_valid;
                wr_drop  = buf_valid;
            end
        end else if (buf_valid) begin
            o_csb0   = 1'b0;
            o_web0   = 1'b0;
            o_addr0  = buf_addr[AW-1:2];
            o_wmask0 = lane_wmask(buf_addr[1:0]);
            o_din0   = {4{buf_data}};
            buf_pop  = 1'b1;
            buf_push = core_wr;
        end else if (core_wr) begin
            o_csb0   = 1'b0;
            o_web0   = 1'b0;
            o_addr0  = i_sram_waddr[AW-1:2];
            o_wmask0 = lane_wmask(i_sram_waddr[1:0]);
            o_din0   = {4{i_sram_wdata}};
        end else if (i_debug_mode && i_wb_dbg_stb && state_q == ST_IDLE) begin
            dbg_go   = 1'b1;
            o_csb0   = 1'b0;
            o_web0   = !i_wb_dbg_we;
            o_addr0  = i_wb_dbg_adr[AW-1:2];
            o_wmask0 = i_wb_dbg_we ? i_wb_dbg_sel : 4'b0000;
            o_din0   = i_wb_dbg_we ? i_wb_dbg_dat : '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            rdt_q   <= '0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (dbg_go) begin
                        state_q <= i_wb_dbg_we ? ST_ACK : ST_RDWAIT;
                        ack_q   <= i_wb_dbg_we;
                    end
                end
                ST_RDWAIT: begin
                    rdt_q   <= i_dout0;
                    state_q <= ST_ACK;
                    ack_q   <= 1'b1;
                end
                ST_ACK:  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Forwarding looks at the buffer as it was before this cycle's push.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_lane_q  <= 2'b00;
            fwd_q      <= 1'b0;
            fwd_data_q <= 8'h00;
            err_q      <= 1'b0;
        end else begin
            if (rd_issue) begin
                rd_lane_q  <= i_sram_raddr[1:0];
                fwd_q      <= buf_hit;
                fwd_data_q <= buf_data;
            end
            if (wr_drop) begin
                err_q <= 1'b1;
            end
        end
    end

    assign o_sram_rdata = fwd_q ? fwd_data_q : lane_byte(i_dout0, rd_lane_q);
    assign o_wb_dbg_rdt = rdt_q;
    assign o_wb_dbg_ack = ack_q;
    assign o_err        = err_q;

`ifdef SUBSERVIENT_SRAM_ARB_STATS_EN
    logic [15:0] defer_cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            defer_cnt_q <= 16'h0000;
        end else if (buf_push && defer_cnt_q != 16'hFFFF) begin
            defer_cnt_q <= defer_cnt_q + 16'h0001;
        end
    end

    assign o_defer_cnt = defer_cnt_q;
`endif

endmodule
